// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter shared by the CPU load/store path and a host/debug port.
// Round-robin grant per cycle; host accesses are acknowledged one cycle after grant.
module dmem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic {ARB, HACK} state_t;
  typedef enum logic {PRIO_CPU, PRIO_HOST} prio_t;

  state_t state, state_nx;
  prio_t  prio, prio_nx;
  logic   host_pend, gnt_cpu, gnt_host;

  always_comb begin
    host_pend = host_req && (state == ARB);
    gnt_cpu   = cpu_req && !reset && (!host_pend || prio == PRIO_CPU);
    gnt_host  = host_pend && !reset && !gnt_cpu;

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_cpu) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (gnt_host) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end

    // Stall is forced low during reset so the CPU is not held by the arbiter's reset.
    cpu_stall = cpu_req && !reset && !gnt_cpu;
    cpu_rdata = mem_rdata;

    prio_nx = prio;
    if (gnt_cpu)       prio_nx = PRIO_HOST;
    else if (gnt_host) prio_nx = PRIO_CPU;

    state_nx = ARB;
    if (gnt_host) state_nx = HACK;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB;
      prio        <= PRIO_CPU;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      stall_count <= '0;
    end else begin
      state    <= state_nx;
      prio     <= prio_nx;
      host_ack <= gnt_host;
      if (gnt_host) host_rdata <= mem_rdata;
      if (cpu_stall && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural dmem, a reference model of the
// grant rules, and a second instance with a 3-bit counter for saturation.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, cpu_req, cpu_we, host_req, host_we;
  logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, host_ack, mem_we;
  logic [15:0] stall_count;

  logic [31:0] s_cpu_rdata, s_host_rdata, s_mem_addr, s_mem_wdata;
  logic        s_cpu_stall, s_host_ack, s_mem_we;
  logic [2:0]  s_stall_count;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_count(stall_count)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .CNT_W(3)) u_sat (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(s_host_rdata), .host_ack(s_host_ack),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .stall_count(s_stall_count)
  );

  // Behavioural dmem: combinational read, write on the rising edge.
  logic [31:0] ram [64] = '{default: 32'h0};
  assign mem_rdata = ram[mem_addr[5:0]];
  always @(posedge clock) if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;

  // Reference model state
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  logic [31:0] sb_q [$];
  bit          host_next_turn = 1'b0;  // a contested grant goes to the host next
  bit          host_just_served = 1'b0;
  bit          exp_ack = 1'b0;
  int unsigned m_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin : monitor
    bit          cw, hw, host_ok, ewe;
    logic [31:0] ea, ed;

    chk("host_ack", {63'h0, host_ack}, {63'h0, exp_ack});
    if (host_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL host_ack_unexpected: got ack expected none (t=%0t)", $time);
      end else begin
        chk("host_rdata", host_rdata, sb_q.pop_front());
      end
    end
    chk("stall_count", stall_count, m_cnt);
    chk("sat_stall_count", s_stall_count, (m_cnt > 7) ? 7 : m_cnt);

    cw = 1'b0;
    hw = 1'b0;
    if (!reset) begin
      host_ok = host_req && !host_just_served;
      cw = cpu_req && (!host_ok || !host_next_turn);
      hw = host_ok && !cw;
    end
    ewe = cw ? cpu_we : (hw ? host_we : 1'b0);
    ea  = cw ? cpu_addr : (hw ? host_addr : 32'h0);
    ed  = cw ? cpu_wdata : (hw ? host_wdata : 32'h0);

    chk("cpu_stall", {63'h0, cpu_stall}, {63'h0, (cpu_req && !reset && !cw)});
    chk("mem_we", {63'h0, mem_we}, {63'h0, ewe});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    if (cw && !cpu_we) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[5:0]]);

    if (reset) begin
      host_next_turn   = 1'b0;
      host_just_served = 1'b0;
      exp_ack          = 1'b0;
      m_cnt            = 0;
    end else begin
      if (hw) sb_q.push_back(ref_mem[host_addr[5:0]]);
      if (cw && cpu_we) ref_mem[cpu_addr[5:0]] = cpu_wdata;
      if (hw && host_we) ref_mem[host_addr[5:0]] = host_wdata;
      if (cw) host_next_turn = 1'b1;
      else if (hw) host_next_turn = 1'b0;
      host_just_served = hw;
      exp_ack          = hw;
      if (cpu_req && !cw && m_cnt < 65535) m_cnt++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic host_txn(input bit we, input logic [31:0] addr, input logic [31:0] data);
    bit done = 1'b0;
    host_we    = we;
    host_addr  = addr;
    host_wdata = data;
    host_req   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (host_ack) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL host_txn_timeout: got no ack expected ack within 8 cycles");
    end
    host_req = 1'b0;
  endtask

  task automatic host_drain();
    bit done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!host_req || host_ack) begin
        done = 1'b1;
        break;
      end
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL host_drain_timeout: got no ack expected ack within 8 cycles");
    end
    host_req = 1'b0;
  endtask

  // mode: 0 = off, 1 = always requesting, 2 = random
  task automatic run_mix(input int n, input int cpu_mode, input int host_mode);
    for (int i = 0; i < n; i++) begin
      cpu_req   = (cpu_mode == 1) || (cpu_mode == 2 && $urandom_range(0, 1) == 1);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 32'($urandom_range(0, 63));
      cpu_wdata = $urandom;
      if (!host_req || host_ack) begin
        host_req   = (host_mode == 1) || (host_mode == 2 && $urandom_range(0, 1) == 1);
        host_we    = $urandom_range(0, 1) == 1;
        host_addr  = 32'($urandom_range(0, 63));
        host_wdata = $urandom;
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (2) step();
    reset = 1'b0;

    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd8; cpu_wdata = 32'd3;
    step();
    chk("ram8_after_store", ram[8], 32'd3);
    cpu_we = 1'b0;
    step();
    cpu_req = 1'b0;

    host_txn(1'b1, 32'd15, 32'hDEADBEEF);
    host_txn(1'b0, 32'd15, 32'h0);
    chk("host_read_15", host_rdata, 32'hDEADBEEF);

    reset = 1'b1;
    step();
    reset = 1'b0;
    run_mix(12, 1, 1);
    run_mix(10, 0, 1);
    run_mix(300, 2, 2);
    cpu_req = 1'b0;
    host_drain();
    step();

    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd4; cpu_wdata = 32'h44;
    step();
    cpu_req = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'd4; host_wdata = 32'hBAD0BAD0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    host_req = 1'b0;
    chk("reset_drops_ack", {63'h0, host_ack}, 64'h0);
    chk("ram4_kept", ram[4], 32'h44);
    host_txn(1'b0, 32'd4, 32'h0);
    chk("host_read_4", host_rdata, 32'h44);

    reset = 1'b1;
    step();
    reset = 1'b0;
    run_mix(20, 1, 1);
    cpu_req = 1'b0;
    host_drain();
    chk("sat_final", s_stall_count, 3'd7);

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
